// File: rtl/apb_pkg.sv
// apb_pkg
//   Shared definitions for the APB completer memories behind the AHB-APB bridge:
//   bus widths, FSM state encoding and the base-address map of the three slaves.
//   No ports; imported with "import apb_pkg::*;".
package apb_pkg;

  localparam int APB_DW = 32;
  localparam int APB_AW = 32;

  // Completer FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ACC  = 2'd2;

  // Slave base-address map, one window per pselx bit
  localparam logic [APB_AW-1:0] SLV0_BASE = 32'h8000_0000;
  localparam logic [APB_AW-1:0] SLV1_BASE = 32'h8400_0000;
  localparam logic [APB_AW-1:0] SLV2_BASE = 32'h8800_0000;

endpackage

// File: rtl/apb_slave_regbank.sv
// apb_slave_regbank
//   DEPTH x 32-bit word storage for one APB completer.
//   Synchronous write port, combinational read port, synchronous clear on hreset.
// Ports
//   hclk     in   clock
//   hreset   in   synchronous active-high clear of every word
//   wr_en    in   write strobe
//   idx      in   word index shared by the write and read ports
//   wr_data  in   write data
//   rd_data  out  combinational read of word idx
module apb_slave_regbank
  import apb_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     hclk,
  input  logic                     hreset,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [APB_DW-1:0]        wr_data,
  output logic [APB_DW-1:0]        rd_data
);

  logic [APB_DW-1:0] mem [DEPTH];

  always_ff @(posedge hclk) begin
    if (hreset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[idx] <= wr_data;
    end
  end

  assign rd_data = mem[idx];

endmodule

// File: rtl/apb_slave_mem.sv
// apb_slave_mem
//   APB completer memory answering one pselx bit of the AHB-APB bridge, with a
//   programmable number of wait states and an error response for misaligned or
//   out-of-window addresses.
// Ports
//   hclk     in   1   clock
//   hreset   in   1   synchronous active-high reset
//   pselx    in   3   peripheral selects, only bit SLV_IDX is honoured
//   penable  in   1   access phase
//   pwrite   in   1   1 = write, 0 = read
//   paddr    in   32  byte address
//   pwdata   in   32  write data
//   prdata   out 32   read data, held until the next read completes
//   pready   out  1   one-cycle completion pulse
//   pslverr  out  1   error, qualified by pready
//
// state | meaning
// IDLE  | no transfer in flight, waiting for a setup phase
// WAIT  | access phase, wait counter running down to zero
// ACC   | transfer completed, pready/pslverr/prdata presented for one cycle
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int          SLV_IDX     = 0,
  parameter int          DEPTH       = 16,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic [2:0]        pselx,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [APB_AW-1:0] paddr,
  input  logic [APB_DW-1:0] pwdata,
  output logic [APB_DW-1:0] prdata,
  output logic              pready,
  output logic              pslverr
);

  localparam int                IDX_W       = $clog2(DEPTH);
  localparam logic [APB_AW-1:0] WIN_BYTES   = APB_AW'(DEPTH * 4);
  localparam logic [3:0]        WAIT_LOAD   = 4'(WAIT_CYCLES);
  localparam logic [2:0]        SEL_MASK    = 3'b001 << SLV_IDX;

  logic [1:0]        state;
  logic [3:0]        cnt;
  logic              sel;
  logic [APB_AW-1:0] off;
  logic              bad;
  logic [IDX_W-1:0]  idx;
  logic              complete;
  logic              mem_we;
  logic [APB_DW-1:0] mem_rdata;

  // Masking keeps every pselx bit in the cone while answering only our own.
  assign sel = |(pselx & SEL_MASK);

  // Addresses below BASE_ADDR wrap to a huge offset and fail the window check.
  assign off = paddr - BASE_ADDR;
  assign bad = (paddr[1:0] != 2'b00) | (off >= WIN_BYTES);
  assign idx = off[IDX_W+1:2];

  assign complete = (state == ST_WAIT) & sel & penable & (cnt == 4'd0);
  assign mem_we   = complete & pwrite & ~bad & ~hreset;

  apb_slave_regbank #(
    .DEPTH (DEPTH)
  ) u_regbank (
    .hclk    (hclk),
    .hreset  (hreset),
    .wr_en   (mem_we),
    .idx     (idx),
    .wr_data (pwdata),
    .rd_data (mem_rdata)
  );

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state   <= ST_IDLE;
      cnt     <= 4'd0;
      prdata  <= '0;
      pready  <= 1'b0;
      pslverr <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (sel && !penable) begin
            state <= ST_WAIT;
            cnt   <= WAIT_LOAD;
          end
        end
        ST_WAIT: begin
          if (!sel) begin
            state <= ST_IDLE;
          end else if (penable) begin
            if (cnt != 4'd0) begin
              cnt <= cnt - 4'd1;
            end else begin
              state   <= ST_ACC;
              pready  <= 1'b1;
              pslverr <= bad;
              if (!pwrite) begin
                prdata <= bad ? '0 : mem_rdata;
              end
            end
          end
        end
        ST_ACC: begin
          pready  <= 1'b0;
          pslverr <= 1'b0;
          // A setup phase presented during the ACC cycle starts the next
          // transfer without passing through IDLE.
          if (sel && !penable) begin
            state <= ST_WAIT;
            cnt   <= WAIT_LOAD;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state   <= ST_IDLE;
          pready  <= 1'b0;
          pslverr <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_slave_mem.sv
module tb_apb_slave_mem;

  localparam int          SLV_IDX     = 0;
  localparam int          DEPTH       = 16;
  localparam int          WAIT_CYCLES = 1;
  localparam logic [31:0] BASE        = 32'h8000_0000;
  localparam int          EXP_LAT     = WAIT_CYCLES + 1;  // edges after setup edge until pready visible

  logic        hclk = 1'b0;
  logic        hreset;
  logic [2:0]  pselx;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_model [DEPTH];
  logic [31:0] prdata_model;

  always #5 hclk = ~hclk;

  apb_slave_mem #(
    .SLV_IDX     (SLV_IDX),
    .DEPTH       (DEPTH),
    .WAIT_CYCLES (WAIT_CYCLES),
    .BASE_ADDR   (BASE)
  ) dut (
    .hclk    (hclk),
    .hreset  (hreset),
    .pselx   (pselx),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr)
  );

  function automatic logic model_bad(input logic [31:0] a);
    logic [31:0] o;
    o = a - BASE;
    return (a % 4 != 0) || (o >= 32'(DEPTH * 4));
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) mem_model[i] = '0;
    prdata_model = '0;
  endtask

  task automatic model_apply(input logic wr, input logic [31:0] a, input logic [31:0] d,
                             output logic exp_err, output logic [31:0] exp_rd);
    int wi;
    exp_err = model_bad(a);
    wi = int'((a - BASE) / 4);
    if (wr && !exp_err) mem_model[wi] = d;
    if (!wr) prdata_model = exp_err ? 32'h0 : mem_model[wi];
    exp_rd = prdata_model;
  endtask

  // Presents a setup phase now, then the access phase; returns at the negedge
  // where pready is seen (lat = edges since the setup edge) or -1 on timeout.
  task automatic xfer(input logic [2:0] sel_bits, input logic wr, input logic [31:0] a,
                      input logic [31:0] d, output int lat, output logic [31:0] rd, output logic err);
    pselx = sel_bits; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(posedge hclk);
    #1 penable = 1'b1;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge hclk);
      @(negedge hclk);
      if (pready === 1'b1) begin
        lat = c;
        break;
      end
    end
    rd  = prdata;
    err = pslverr;
  endtask

  task automatic go_idle();
    pselx = 3'b000; penable = 1'b0; pwrite = 1'b0;
    @(posedge hclk);
    @(negedge hclk);
  endtask

  task automatic test_reset();
    hreset = 1'b1; pselx = 3'b000; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    repeat (3) @(posedge hclk);
    @(negedge hclk);
    hreset = 1'b0;
    model_clear();
    checks++;
    if (pready !== 1'b0 || pslverr !== 1'b0 || prdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: pready=%b pslverr=%b prdata=%h expected 0 0 00000000", pready, pslverr, prdata);
    end
    @(negedge hclk);
  endtask

  task automatic test_single_write();
    int lat; logic [31:0] rd, erd; logic err, eerr;
    xfer(3'b001, 1'b1, BASE + 32'h4, 32'hDEAD_BEEF, lat, rd, err);
    model_apply(1'b1, BASE + 32'h4, 32'hDEAD_BEEF, eerr, erd);
    checks++;
    if (lat != EXP_LAT || err !== eerr) begin
      errors++;
      $display("FAIL single_write: lat=%0d err=%b expected lat=%0d err=%b", lat, err, EXP_LAT, eerr);
    end
    go_idle();
    checks++;
    if (pready !== 1'b0) begin
      errors++;
      $display("FAIL single_write_pulse: pready=%b expected 0", pready);
    end
  endtask

  task automatic test_single_read();
    int lat; logic [31:0] rd, erd; logic err, eerr;
    xfer(3'b001, 1'b0, BASE + 32'h4, 32'h0, lat, rd, err);
    model_apply(1'b0, BASE + 32'h4, 32'h0, eerr, erd);
    checks++;
    if (lat != EXP_LAT || err !== 1'b0 || rd !== 32'hDEAD_BEEF || rd !== erd) begin
      errors++;
      $display("FAIL single_read: lat=%0d err=%b prdata=%h expected lat=%0d err=0 prdata=deadbeef", lat, err, rd, EXP_LAT);
    end
    go_idle();
  endtask

  task automatic test_burst();
    int lat; logic [31:0] rd, erd; logic err, eerr;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 4; i++) begin
        logic [31:0] a, d;
        a = BASE + 32'(4 * i);
        d = 32'(8'h11 * (i + 1));
        xfer(3'b001, pass == 0, a, d, lat, rd, err);
        model_apply(pass == 0, a, d, eerr, erd);
        checks++;
        if (lat != EXP_LAT || err !== 1'b0 || (pass == 1 && rd !== d)) begin
          errors++;
          $display("FAIL burst_p%0d_b%0d: lat=%0d err=%b prdata=%h expected lat=%0d err=0 prdata=%h",
                   pass, i, lat, err, rd, EXP_LAT, d);
        end
      end
      go_idle();
    end
  endtask

  task automatic test_errors();
    int lat; logic [31:0] rd, erd; logic err, eerr;
    xfer(3'b001, 1'b0, BASE + 32'h40, 32'h0, lat, rd, err);
    model_apply(1'b0, BASE + 32'h40, 32'h0, eerr, erd);
    checks++;
    if (lat != EXP_LAT || err !== 1'b1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL err_read_oor: lat=%0d err=%b prdata=%h expected lat=%0d err=1 prdata=0", lat, err, rd, EXP_LAT);
    end
    go_idle();
    xfer(3'b001, 1'b1, BASE + 32'h2, 32'hFFFF_FFFF, lat, rd, err);
    model_apply(1'b1, BASE + 32'h2, 32'hFFFF_FFFF, eerr, erd);
    checks++;
    if (lat != EXP_LAT || err !== 1'b1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL err_write_misaligned: lat=%0d err=%b prdata=%h expected lat=%0d err=1 prdata=0", lat, err, rd, EXP_LAT);
    end
    go_idle();
    xfer(3'b001, 1'b0, BASE, 32'h0, lat, rd, err);
    model_apply(1'b0, BASE, 32'h0, eerr, erd);
    checks++;
    if (err !== 1'b0 || rd !== 32'h11) begin
      errors++;
      $display("FAIL err_mem_unchanged: err=%b prdata=%h expected err=0 prdata=00000011", err, rd);
    end
    go_idle();
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] rd, erd; logic err, eerr; logic seen;
    pselx = 3'b001; penable = 1'b0; pwrite = 1'b1; paddr = BASE + 32'h8; pwdata = 32'hCAFE_F00D;
    @(posedge hclk);
    #1 penable = 1'b1;
    @(posedge hclk);
    #1 hreset = 1'b1;
    seen = 1'b0;
    @(posedge hclk);
    @(negedge hclk);
    if (pready !== 1'b0) seen = 1'b1;
    hreset = 1'b0; pselx = 3'b000; penable = 1'b0; pwrite = 1'b0;
    model_clear();
    @(posedge hclk);
    @(negedge hclk);
    if (pready !== 1'b0) seen = 1'b1;
    checks++;
    if (seen || prdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_outputs: pready_seen=%b prdata=%h expected 0 00000000", seen, prdata);
    end
    xfer(3'b001, 1'b0, BASE + 32'h8, 32'h0, lat, rd, err);
    model_apply(1'b0, BASE + 32'h8, 32'h0, eerr, erd);
    checks++;
    if (lat != EXP_LAT || err !== 1'b0 || rd !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_mem2: lat=%0d err=%b prdata=%h expected lat=%0d err=0 prdata=0", lat, err, rd, EXP_LAT);
    end
    go_idle();
  endtask

  task automatic test_select_isolation();
    int lat; logic [31:0] rd, erd; logic err, eerr; logic seen;
    xfer(3'b001, 1'b1, BASE + 32'hC, 32'h1234_5678, lat, rd, err);
    model_apply(1'b1, BASE + 32'hC, 32'h1234_5678, eerr, erd);
    go_idle();
    xfer(3'b010, 1'b1, BASE + 32'hC, 32'hBAD0_BAD0, lat, rd, err);
    checks++;
    if (lat != -1) begin
      errors++;
      $display("FAIL select_isolation: pready after %0d cycles expected none", lat);
    end
    go_idle();
    // Abort: select dropped while the wait counter is running.
    pselx = 3'b001; penable = 1'b0; pwrite = 1'b1; paddr = BASE + 32'hC; pwdata = 32'h5555_AAAA;
    @(posedge hclk);
    #1 penable = 1'b1;
    @(posedge hclk);
    #1 pselx = 3'b000; penable = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge hclk);
      if (pready !== 1'b0) seen = 1'b1;
      @(posedge hclk);
    end
    @(negedge hclk);
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL abort_pready: pready seen=%b expected 0", seen);
    end
    xfer(3'b001, 1'b0, BASE + 32'hC, 32'h0, lat, rd, err);
    model_apply(1'b0, BASE + 32'hC, 32'h0, eerr, erd);
    checks++;
    if (rd !== 32'h1234_5678 || rd !== erd) begin
      errors++;
      $display("FAIL abort_no_write: prdata=%h expected 12345678", rd);
    end
    go_idle();
  endtask

  task automatic test_random();
    int lat; logic [31:0] rd, erd, a, d; logic err, eerr, wr;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
        3:       a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3));
        4:       a = BASE + 32'(DEPTH * 4) + 32'(4 * $urandom_range(0, 100));
        default: a = BASE - 32'(4 * $urandom_range(1, 8));
      endcase
      wr = 1'($urandom_range(0, 1));
      d  = $urandom;
      xfer({2'($urandom_range(0, 3)), 1'b1}, wr, a, d, lat, rd, err);
      model_apply(wr, a, d, eerr, erd);
      checks++;
      if (lat != EXP_LAT || err !== eerr || rd !== erd) begin
        errors++;
        $display("FAIL random_%0d: wr=%b addr=%h lat=%0d err=%b prdata=%h expected lat=%0d err=%b prdata=%h",
                 n, wr, a, lat, err, rd, EXP_LAT, eerr, erd);
      end
      if ($urandom_range(0, 2) == 0) begin
        go_idle();
        checks++;
        if (pready !== 1'b0) begin
          errors++;
          $display("FAIL random_pulse_%0d: pready=%b expected 0", n, pready);
        end
      end
    end
    go_idle();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_burst();
    test_errors();
    test_reset_mid();
    test_select_isolation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
